// File: rtl/sap_pkg.sv
// Shared definitions for the SAP bus-centred datapath.
package sap_pkg;

    // Bus-source codes above the general registers, relative to NUM_REGS.
    localparam int SRC_OFS_IR  = 0;
    localparam int SRC_OFS_ALU = 1;
    localparam int SRC_OFS_RAM = 2;
    localparam int SRC_OFS_PC  = 3;

    // Select width needed to address all registers plus the four extra sources.
    function automatic int sel_width(input int num_regs);
        return $clog2(num_regs + 4);
    endfunction

endpackage

// File: rtl/sap_out_fifo.sv
// Output-port FIFO: first-word fall-through, valid/ready drain, sticky overflow.
// A push into a full FIFO is still accepted when a pop frees a slot on the same edge.
module sap_out_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       arst_l,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop_ready,
    output logic [DATA_W-1:0]          head,
    output logic                       valid,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              full;
    logic              pop;
    logic              push_ok;

    assign valid   = (level != '0);
    assign full    = (level == LVL_W'(DEPTH));
    assign pop     = valid & pop_ready;
    assign push_ok = push & (~full | pop);
    assign head    = valid ? mem[rd_ptr] : '0;

    // Storage write for accepted pushes.
    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer, occupancy and overflow bookkeeping.
    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push_ok && !pop) begin
                level <= level + LVL_W'(1);
            end else if (pop && !push_ok) begin
                level <= level - LVL_W'(1);
            end
            if (push && !push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sap_bus_datapath.sv
// SAP datapath core: general registers, IR, PC, shared encoded-select bus and
// a buffered output port. Architectural state moves only on strobe-qualified
// edges; the output port drains at full clock rate.
module sap_bus_datapath
    import sap_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int NUM_REGS  = 4,
    parameter int PC_W      = 8,
    parameter int IMM_W     = 8,
    parameter int OUT_DEPTH = 4
) (
    input  logic                               CLK,
    input  logic                               ARST_L,
    input  logic                               SLOW_CLOCK_STRB,
    input  logic                               HALT,
    input  logic                               SRC_EN,
    input  logic [sel_width(NUM_REGS)-1:0]     SRC_SEL,
    input  logic [NUM_REGS-1:0]                REG_WR,
    input  logic [NUM_REGS-1:0]                REG_MOV,
    input  logic                               IR_WR,
    input  logic                               PC_COUNT,
    input  logic                               BRANCH,
    input  logic                               OUT_WR,
    input  logic [DATA_W-1:0]                  ALU_DATA,
    input  logic [DATA_W-1:0]                  RAM_DATA,
    output logic [DATA_W-1:0]                  BUS,
    output logic [NUM_REGS*DATA_W-1:0]         REG_FLAT,
    output logic [DATA_W-1:0]                  IR,
    output logic [PC_W-1:0]                    PC,
    output logic [DATA_W-1:0]                  OUT_DATA,
    output logic                               OUT_VALID,
    input  logic                               OUT_READY,
    output logic [$clog2(OUT_DEPTH+1)-1:0]     OUT_LEVEL,
    output logic                               OUT_OVERFLOW
);

    localparam int SEL_W = sel_width(NUM_REGS);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] ir_q;
    logic [PC_W-1:0]   pc_q;
    logic [DATA_W-1:0] bus_mux;
    logic [DATA_W-1:0] imm_ext;
    logic              upd;

    assign upd     = SLOW_CLOCK_STRB & ~HALT;
    assign imm_ext = DATA_W'(bus_mux[IMM_W-1:0]);

    // Bus source mux; unused select codes and a disabled driver give zero.
    always_comb begin
        bus_mux = '0;
        if (SRC_EN) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (SRC_SEL == SEL_W'(i)) begin
                    bus_mux = regs[i];
                end
            end
            if (SRC_SEL == SEL_W'(NUM_REGS + SRC_OFS_IR)) begin
                bus_mux = ir_q;
            end
            if (SRC_SEL == SEL_W'(NUM_REGS + SRC_OFS_ALU)) begin
                bus_mux = ALU_DATA;
            end
            if (SRC_SEL == SEL_W'(NUM_REGS + SRC_OFS_RAM)) begin
                bus_mux = RAM_DATA;
            end
            if (SRC_SEL == SEL_W'(NUM_REGS + SRC_OFS_PC)) begin
                bus_mux = DATA_W'(pc_q);
            end
        end
    end

    assign BUS = bus_mux;

    // General registers: full-word load wins over immediate load.
    always_ff @(posedge CLK or negedge ARST_L) begin
        if (!ARST_L) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (upd) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (REG_WR[i]) begin
                    regs[i] <= bus_mux;
                end else if (REG_MOV[i]) begin
                    regs[i] <= imm_ext;
                end
            end
        end
    end

    // Instruction register.
    always_ff @(posedge CLK or negedge ARST_L) begin
        if (!ARST_L) begin
            ir_q <= '0;
        end else if (upd && IR_WR) begin
            ir_q <= bus_mux;
        end
    end

    // Program counter: branch beats increment; increment wraps naturally.
    always_ff @(posedge CLK or negedge ARST_L) begin
        if (!ARST_L) begin
            pc_q <= '0;
        end else if (upd) begin
            if (BRANCH) begin
                pc_q <= bus_mux[PC_W-1:0];
            end else if (PC_COUNT) begin
                pc_q <= pc_q + PC_W'(1);
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign REG_FLAT[g*DATA_W +: DATA_W] = regs[g];
    end

    assign IR = ir_q;
    assign PC = pc_q;

    sap_out_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (OUT_DEPTH)
    ) u_out_fifo (
        .clk       (CLK),
        .arst_l    (ARST_L),
        .push      (upd & OUT_WR),
        .push_data (bus_mux),
        .pop_ready (OUT_READY),
        .head      (OUT_DATA),
        .valid     (OUT_VALID),
        .level     (OUT_LEVEL),
        .overflow  (OUT_OVERFLOW)
    );

endmodule

// File: tb/tb_sap_bus_datapath.sv
// Bench for sap_bus_datapath: directed scenarios followed by random traffic,
// all compared against a behavioural model of registers, PC and a word queue.
module tb_sap_bus_datapath;

    localparam int DATA_W    = 16;
    localparam int NUM_REGS  = 4;
    localparam int PC_W      = 8;
    localparam int IMM_W     = 8;
    localparam int OUT_DEPTH = 4;

    logic        CLK = 1'b0;
    logic        ARST_L;
    logic        SLOW_CLOCK_STRB;
    logic        HALT;
    logic        SRC_EN;
    logic [2:0]  SRC_SEL;
    logic [3:0]  REG_WR;
    logic [3:0]  REG_MOV;
    logic        IR_WR;
    logic        PC_COUNT;
    logic        BRANCH;
    logic        OUT_WR;
    logic [15:0] ALU_DATA;
    logic [15:0] RAM_DATA;
    logic [15:0] BUS;
    logic [63:0] REG_FLAT;
    logic [15:0] IR;
    logic [7:0]  PC;
    logic [15:0] OUT_DATA;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [2:0]  OUT_LEVEL;
    logic        OUT_OVERFLOW;

    sap_bus_datapath #(
        .DATA_W    (DATA_W),
        .NUM_REGS  (NUM_REGS),
        .PC_W      (PC_W),
        .IMM_W     (IMM_W),
        .OUT_DEPTH (OUT_DEPTH)
    ) dut (
        .CLK             (CLK),
        .ARST_L          (ARST_L),
        .SLOW_CLOCK_STRB (SLOW_CLOCK_STRB),
        .HALT            (HALT),
        .SRC_EN          (SRC_EN),
        .SRC_SEL         (SRC_SEL),
        .REG_WR          (REG_WR),
        .REG_MOV         (REG_MOV),
        .IR_WR           (IR_WR),
        .PC_COUNT        (PC_COUNT),
        .BRANCH          (BRANCH),
        .OUT_WR          (OUT_WR),
        .ALU_DATA        (ALU_DATA),
        .RAM_DATA        (RAM_DATA),
        .BUS             (BUS),
        .REG_FLAT        (REG_FLAT),
        .IR              (IR),
        .PC              (PC),
        .OUT_DATA        (OUT_DATA),
        .OUT_VALID       (OUT_VALID),
        .OUT_READY       (OUT_READY),
        .OUT_LEVEL       (OUT_LEVEL),
        .OUT_OVERFLOW    (OUT_OVERFLOW)
    );

    always #5 CLK = ~CLK;

    // Behavioural model state.
    logic [15:0] m_regs [4];
    logic [15:0] m_ir;
    logic [7:0]  m_pc;
    logic [15:0] m_q [$];
    logic        m_ovf;

    int n_vec;
    int n_err;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 4; i++) m_regs[i] = 16'h0;
        m_ir  = 16'h0;
        m_pc  = 8'h0;
        m_ovf = 1'b0;
        m_q.delete();
    endtask

    function automatic logic [15:0] m_bus();
        int s;
        s = int'(SRC_SEL);
        if (!SRC_EN) return 16'h0;
        if (s < 4) return m_regs[s];
        case (s - 4)
            0:       return m_ir;
            1:       return ALU_DATA;
            2:       return RAM_DATA;
            3:       return {8'h00, m_pc};
            default: return 16'h0;
        endcase
    endfunction

    task automatic clear_in();
        SLOW_CLOCK_STRB = 1'b0;
        HALT      = 1'b0;
        SRC_EN    = 1'b0;
        SRC_SEL   = 3'd0;
        REG_WR    = 4'h0;
        REG_MOV   = 4'h0;
        IR_WR     = 1'b0;
        PC_COUNT  = 1'b0;
        BRANCH    = 1'b0;
        OUT_WR    = 1'b0;
        OUT_READY = 1'b0;
        ALU_DATA  = 16'h0;
        RAM_DATA  = 16'h0;
    endtask

    task automatic check_all(input string tag);
        logic [63:0] flat;
        for (int i = 0; i < 4; i++) flat[i*16 +: 16] = m_regs[i];
        chk({tag, "_regs"},  REG_FLAT, flat);
        chk({tag, "_ir"},    IR, m_ir);
        chk({tag, "_pc"},    PC, m_pc);
        chk({tag, "_valid"}, OUT_VALID, m_q.size() != 0);
        chk({tag, "_level"}, OUT_LEVEL, m_q.size());
        chk({tag, "_data"},  OUT_DATA, (m_q.size() != 0) ? m_q[0] : 16'h0);
        chk({tag, "_ovf"},   OUT_OVERFLOW, m_ovf);
    endtask

    // Called at posedge+1 with inputs already applied; advances one clock.
    task automatic cycle(input string tag);
        logic [15:0] b;
        logic        upd;
        logic        pop;
        logic        push;
        #1;
        b = m_bus();
        chk({tag, "_bus"}, BUS, b);
        upd = SLOW_CLOCK_STRB & ~HALT;
        pop = (m_q.size() != 0) && OUT_READY;
        for (int i = 0; i < 4; i++) begin
            if (upd && REG_WR[i])       m_regs[i] = b;
            else if (upd && REG_MOV[i]) m_regs[i] = {8'h00, b[7:0]};
        end
        if (upd && IR_WR) m_ir = b;
        if (upd && BRANCH)        m_pc = b[7:0];
        else if (upd && PC_COUNT) m_pc = m_pc + 8'd1;
        push = upd && OUT_WR;
        if (push && m_q.size() >= OUT_DEPTH && !pop) begin
            m_ovf = 1'b1;
            push  = 1'b0;
        end
        if (pop)  void'(m_q.pop_front());
        if (push) m_q.push_back(b);
        @(posedge CLK);
        #1;
        check_all(tag);
    endtask

    task automatic pulse_reset(input string tag);
        ARST_L = 1'b0;
        m_reset();
        #1;
        check_all(tag);
        ARST_L = 1'b1;
    endtask

    initial begin
        logic [15:0] drain_exp [4];
        n_vec = 0;
        n_err = 0;
        clear_in();
        m_reset();
        ARST_L = 1'b0;
        repeat (2) @(posedge CLK);
        #3 ARST_L = 1'b1;
        #1 check_all("reset");
        @(posedge CLK);
        #1;

        // MOV truncates to the immediate; WR wins when both are set.
        SRC_EN = 1'b1; SRC_SEL = 3'd5; ALU_DATA = 16'hA5C3;
        REG_MOV = 4'b0010; SLOW_CLOCK_STRB = 1'b1;
        cycle("mov");
        chk("mov_reg1", REG_FLAT[31:16], 16'h00C3);
        chk("mov_others", {REG_FLAT[63:32], REG_FLAT[15:0]}, 48'h0);
        REG_WR = 4'b0010;
        cycle("wr_pri");
        chk("wr_pri_reg1", REG_FLAT[31:16], 16'hA5C3);

        // Strobe and HALT qualification.
        clear_in();
        SRC_EN = 1'b1; SRC_SEL = 3'd5; ALU_DATA = 16'h1234; REG_WR = 4'b0001;
        cycle("no_strb");
        chk("no_strb_reg0", REG_FLAT[15:0], 16'h0);
        SLOW_CLOCK_STRB = 1'b1; HALT = 1'b1;
        cycle("halt");
        chk("halt_reg0", REG_FLAT[15:0], 16'h0);
        HALT = 1'b0;
        cycle("run");
        chk("run_reg0", REG_FLAT[15:0], 16'h1234);

        // PC wrap and branch priority.
        clear_in();
        PC_COUNT = 1'b1; SLOW_CLOCK_STRB = 1'b1;
        repeat (256) cycle("pc_inc");
        chk("pc_wrap", PC, 8'h00);
        BRANCH = 1'b1; SRC_EN = 1'b1; SRC_SEL = 3'd5; ALU_DATA = 16'hFF40;
        cycle("branch");
        chk("branch_pc", PC, 8'h40);

        // Fill past full, then drain.
        clear_in();
        SRC_EN = 1'b1; SRC_SEL = 3'd5; OUT_WR = 1'b1; SLOW_CLOCK_STRB = 1'b1;
        for (int v = 1; v <= 5; v++) begin
            ALU_DATA = 16'(v);
            cycle("fill");
        end
        chk("fill_level", OUT_LEVEL, 3'd4);
        chk("fill_ovf", OUT_OVERFLOW, 1'b1);
        chk("fill_head", OUT_DATA, 16'h0001);
        clear_in();
        OUT_READY = 1'b1;
        for (int v = 1; v <= 4; v++) begin
            chk("drain_head", OUT_DATA, 16'(v));
            cycle("drain");
        end
        chk("drain_empty", OUT_VALID, 1'b0);

        // Push while full and popping on the same edge.
        pulse_reset("rst_full");
        SRC_EN = 1'b1; SRC_SEL = 3'd5; OUT_WR = 1'b1; SLOW_CLOCK_STRB = 1'b1;
        OUT_READY = 1'b0;
        for (int v = 0; v < 4; v++) begin
            ALU_DATA = 16'h0011 + 16'(v);
            cycle("fill2");
        end
        OUT_READY = 1'b1; ALU_DATA = 16'h0099;
        cycle("pushpop");
        chk("pushpop_level", OUT_LEVEL, 3'd4);
        chk("pushpop_ovf", OUT_OVERFLOW, 1'b0);
        clear_in();
        OUT_READY = 1'b1;
        drain_exp = '{16'h0012, 16'h0013, 16'h0014, 16'h0099};
        for (int k = 0; k < 4; k++) begin
            chk("pushpop_order", OUT_DATA, drain_exp[k]);
            cycle("drain2");
        end

        // Async reset while draining with a non-zero PC.
        clear_in();
        SRC_EN = 1'b1; SRC_SEL = 3'd5; ALU_DATA = 16'h0077;
        BRANCH = 1'b1; SLOW_CLOCK_STRB = 1'b1;
        cycle("br77");
        BRANCH = 1'b0; OUT_WR = 1'b1;
        repeat (3) cycle("fill3");
        chk("pre_rst_level", OUT_LEVEL, 3'd3);
        clear_in();
        OUT_READY = 1'b1;
        #2 ARST_L = 1'b0;
        #1;
        chk("arst_valid", OUT_VALID, 1'b0);
        chk("arst_level", OUT_LEVEL, 3'd0);
        chk("arst_pc", PC, 8'h00);
        m_reset();
        #1 ARST_L = 1'b1;

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            SLOW_CLOCK_STRB = ($urandom_range(0, 3) != 0);
            HALT      = ($urandom_range(0, 7) == 0);
            SRC_EN    = ($urandom_range(0, 7) != 0);
            SRC_SEL   = 3'($urandom_range(0, 7));
            REG_WR    = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            REG_MOV   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            IR_WR     = ($urandom_range(0, 3) == 0);
            PC_COUNT  = ($urandom_range(0, 1) == 0);
            BRANCH    = ($urandom_range(0, 5) == 0);
            OUT_WR    = ($urandom_range(0, 1) == 0);
            OUT_READY = ($urandom_range(0, 2) != 0);
            ALU_DATA  = 16'($urandom);
            RAM_DATA  = 16'($urandom);
            if ($urandom_range(0, 63) == 0) begin
                pulse_reset("rnd_rst");
            end
            cycle("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
